// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer reusing one full-adder cell for WIDTH cycles; define SERIAL_SUB_EN to add the op port and subtraction
module serial_add_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q, acc_d, b_in;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, cy_q;
  logic             s1, c1, s_bit, c2, co, c_in, cy_d, accept, last;

  serial_add_ha u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(s1),    .c(c1));
  serial_add_ha u_ha1 (.x(s1),     .y(c_q),    .s(s_bit), .c(c2));

  assign co     = c1 | c2;
  assign acc_d  = {s_bit, acc_q[WIDTH-1:1]};
  assign accept = start && (state_q != RUN);
  assign last   = cnt_q == CW'(WIDTH - 1);

`ifdef SERIAL_SUB_EN
  logic sub_q;
  // remember the captured operation so the final carry can be reported as a borrow
  always_ff @(posedge clk) sub_q <= rst ? 1'b0 : accept ? op : sub_q;
  assign b_in = op ? ~b : b;
  assign c_in = op;
  assign cy_d = co ^ sub_q;
`else
  assign b_in = b;
  assign c_in = 1'b0;
  assign cy_d = co;
`endif

  // sequencer: capture operands, feed one bit per cycle through the cell, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cy_q    <= 1'b0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_d;
      c_q   <= co;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        sum_q   <= acc_d;
        cy_q    <= cy_d;
      end
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        a_q     <= a;
        b_q     <= b_in;
        acc_q   <= '0;
        cnt_q   <= '0;
        c_q     <= c_in;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cy   = cy_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. Reuses a single one-bit adder cell (two half-adder cells plus carry OR) for WIDTH consecutive cycles, so an N-bit add costs one adder cell instead of N. Sits between a requesting datapath and the shared adder cell. Owns operand shifting, carry storage, bit counting and a start/busy/done handshake.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- op  in  1  0=add, 1=subtract; present only with SERIAL_SUB_EN; captured on an accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when sum/cy are valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cy  out  1  carry-out (add) or borrow-out (subtract), held with sum.

## Operation

- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: busy=0, done=0. start=1 → capture a and b into shift registers, clear sum register, bit counter=0, carry register=0 → RUN.
- RUN: busy=1. Each cycle:
  - The adder cell computes the LSB of A, the LSB of B and the carry register.
  - The sum bit shifts into the MSB of the sum register, with the register shifting right.
  - A and B shift right, the carry register takes the cell carry, and the counter increments.
  - When the counter reaches WIDTH-1 in a cycle, that cycle processes the last bit → DONE.
- DONE: busy=0, done=1 for exactly one cycle. cy = final carry register.
  - start=1 → immediate re-capture as in IDLE → RUN (back-to-back).
  - Otherwise → IDLE.
- sum and cy are updated only on the transition into DONE. They hold their value in IDLE and through the next RUN, until the next DONE.
- start while busy=1 is ignored: no capture, no queueing.
- Arithmetic is modulo 2^WIDTH. cy is the (WIDTH+1)th bit.
- Bit counter width is clog2(WIDTH).

## Timing

- Reset values: busy=0, done=0, sum=0, cy=0. State=IDLE, all internal registers 0.
- Start accepted on edge k → busy=1 from k+1 to k+WIDTH inclusive. done=1 and sum/cy valid in cycle k+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- Throughput is one operation per WIDTH+1 cycles when start is asserted in each DONE cycle.
- rst=1 in any state, including mid-RUN, returns to IDLE at the next edge with reset values. The partial result is discarded and no done is produced.
- rst has priority over start in the same cycle.

## Configuration

- SERIAL_SUB_EN defined:
  - The op port exists.
  - On capture with op=1:
    - B is stored inverted.
    - The carry register initialises to 1.
    - cy reports the inverse of the final carry (borrow: 1 when A<B unsigned).
  - op=0 behaves as plain add.
- SERIAL_SUB_EN undefined:
  - No op port.
  - Add only; the carry register always initialises to 0.
  - No inversion logic is synthesised.

## Test plan

All scenarios use WIDTH=8.

- Reset, then idle 5 cycles → busy=0, done=0, sum=0x00, cy=0 throughout.
- start with a=0x5A, b=0x3C → busy for 8 cycles; done pulse 9 cycles after start edge with sum=0x96, cy=0. Outputs hold after done drops.
- start with a=0xFF, b=0x01, then start=1 again at cycles 3 and 5 with a=0x00, b=0x00 → re-starts ignored; done once with sum=0x00, cy=1.
- start with a=0x12, b=0x34; rst=1 on the 4th RUN cycle → next cycle busy=0, sum=0x00, cy=0; no done pulse within 12 cycles.
- Back-to-back:
  - start a=0x01, b=0x02, then start=1 in the DONE cycle with a=0x80, b=0x80.
  - First done: sum=0x03, cy=0.
  - Second done exactly 9 cycles later: sum=0x00, cy=1.
- With SERIAL_SUB_EN, op=1:
  - a=0x10, b=0x20 → sum=0xF0, cy=1.
  - a=0x20, b=0x10 → sum=0x10, cy=0.
